// File: rtl/model_loader.sv
// Streams a framed model (header, position records, index records) from a byte
// source into the position and index BRAM write ports, then appends the index terminator.
module model_loader (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic             byte_valid_in,
    input  logic [7:0]       byte_in,
    output logic             pos_we_out,
    output logic [11:0]      pos_addr_out,
    output logic [2:0][31:0] pos_data_out,
    output logic             idx_we_out,
    output logic [15:0]      idx_addr_out,
    output logic [2:0][11:0] idx_data_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             error_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_POS,
        S_IDX,
        S_TERM,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       byte_cnt_q, byte_cnt_d;
    logic [15:0]      rec_cnt_q, rec_cnt_d;
    logic [11:0]      p_q, p_d;
    logic [15:0]      n_q, n_d;
    logic [87:0]      asm_q, asm_d;
    logic             err_q, err_d;
    logic             pos_we_q, pos_we_d;
    logic [11:0]      pos_addr_q, pos_addr_d;
    logic [2:0][31:0] pos_data_q, pos_data_d;
    logic             idx_we_q, idx_we_d;
    logic [15:0]      idx_addr_q, idx_addr_d;
    logic [2:0][11:0] idx_data_q, idx_data_d;

    // The newest byte sits on top, so after the final byte of a record
    // byte 0 of that record is at bit 0 of the 12-byte window.
    logic [95:0] shifted;
    assign shifted = {byte_in, asm_q};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        rec_cnt_d  = rec_cnt_q;
        p_d        = p_q;
        n_d        = n_q;
        asm_d      = asm_q;
        err_d      = err_q;
        pos_we_d   = 1'b0;
        pos_addr_d = pos_addr_q;
        pos_data_d = pos_data_q;
        idx_we_d   = 1'b0;
        idx_addr_d = idx_addr_q;
        idx_data_d = idx_data_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_in) begin
                    state_d    = S_HEADER;
                    byte_cnt_d = 4'd0;
                    rec_cnt_d  = 16'd0;
                    p_d        = 12'd0;
                    n_d        = 16'd0;
                    err_d      = 1'b0;
                end
            end

            S_HEADER: begin
                if (byte_valid_in) begin
                    asm_d = shifted[95:8];
                    if (byte_cnt_q == 4'd3) begin
                        byte_cnt_d = 4'd0;
                        rec_cnt_d  = 16'd0;
                        n_d        = shifted[95:80];
                        // 12'hFFF is reserved for the terminator, so cap at 4095 entries
                        if (shifted[79:76] != 4'd0) begin
                            p_d   = 12'hFFF;
                            err_d = 1'b1;
                        end else begin
                            p_d = shifted[75:64];
                        end
                        if (shifted[79:64] != 16'd0) begin
                            state_d = S_POS;
                        end else if (shifted[95:80] != 16'd0) begin
                            state_d = S_IDX;
                        end else begin
                            state_d = S_TERM;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end
            end

            S_POS: begin
                if (byte_valid_in) begin
                    asm_d = shifted[95:8];
                    if (byte_cnt_q == 4'd11) begin
                        byte_cnt_d    = 4'd0;
                        pos_we_d      = 1'b1;
                        pos_addr_d    = rec_cnt_q[11:0];
                        pos_data_d[0] = shifted[31:0];
                        pos_data_d[1] = shifted[63:32];
                        pos_data_d[2] = shifted[95:64];
                        if (rec_cnt_q[11:0] == p_q - 12'd1) begin
                            rec_cnt_d = 16'd0;
                            state_d   = (n_q != 16'd0) ? S_IDX : S_TERM;
                        end else begin
                            rec_cnt_d = rec_cnt_q + 16'd1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end
            end

            S_IDX: begin
                if (byte_valid_in) begin
                    asm_d = shifted[95:8];
                    if (byte_cnt_q == 4'd5) begin
                        byte_cnt_d    = 4'd0;
                        idx_we_d      = 1'b1;
                        idx_addr_d    = rec_cnt_q;
                        idx_data_d[2] = shifted[59:48];
                        idx_data_d[1] = shifted[75:64];
                        idx_data_d[0] = shifted[91:80];
                        if (shifted[59:48] >= p_q) begin
                            err_d = 1'b1;
                        end
                        if (rec_cnt_q == n_q - 16'd1) begin
                            state_d = S_TERM;
                        end else begin
                            rec_cnt_d = rec_cnt_q + 16'd1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end
            end

            S_TERM: begin
                idx_we_d      = 1'b1;
                idx_addr_d    = n_q;
                idx_data_d[2] = 12'hFFF;
                idx_data_d[1] = 12'h000;
                idx_data_d[0] = 12'h000;
                state_d       = S_DONE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 4'd0;
            rec_cnt_q  <= 16'd0;
            p_q        <= 12'd0;
            n_q        <= 16'd0;
            asm_q      <= 88'd0;
            err_q      <= 1'b0;
            pos_we_q   <= 1'b0;
            pos_addr_q <= 12'd0;
            pos_data_q <= '0;
            idx_we_q   <= 1'b0;
            idx_addr_q <= 16'd0;
            idx_data_q <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            rec_cnt_q  <= rec_cnt_d;
            p_q        <= p_d;
            n_q        <= n_d;
            asm_q      <= asm_d;
            err_q      <= err_d;
            pos_we_q   <= pos_we_d;
            pos_addr_q <= pos_addr_d;
            pos_data_q <= pos_data_d;
            idx_we_q   <= idx_we_d;
            idx_addr_q <= idx_addr_d;
            idx_data_q <= idx_data_d;
        end
    end

    assign pos_we_out   = pos_we_q;
    assign pos_addr_out = pos_addr_q;
    assign pos_data_out = pos_data_q;
    assign idx_we_out   = idx_we_q;
    assign idx_addr_out = idx_addr_q;
    assign idx_data_out = idx_data_q;
    assign error_out    = err_q;
    assign done_out     = (state_q == S_DONE);
    assign busy_out     = (state_q == S_HEADER) || (state_q == S_POS) ||
                          (state_q == S_IDX) || (state_q == S_TERM);

endmodule

// File: tb/tb_model_loader.sv
// Scoreboard bench for model_loader: stimulus tasks queue the expected writes,
// a negedge monitor pops and compares every write the loader issues.
module tb_model_loader;

    logic             clk_in = 1'b0;
    logic             rst_n_in;
    logic             start_in;
    logic             byte_valid_in;
    logic [7:0]       byte_in;
    logic             pos_we_out;
    logic [11:0]      pos_addr_out;
    logic [2:0][31:0] pos_data_out;
    logic             idx_we_out;
    logic [15:0]      idx_addr_out;
    logic [2:0][11:0] idx_data_out;
    logic             busy_out;
    logic             done_out;
    logic             error_out;

    model_loader dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .start_in      (start_in),
        .byte_valid_in (byte_valid_in),
        .byte_in       (byte_in),
        .pos_we_out    (pos_we_out),
        .pos_addr_out  (pos_addr_out),
        .pos_data_out  (pos_data_out),
        .idx_we_out    (idx_we_out),
        .idx_addr_out  (idx_addr_out),
        .idx_data_out  (idx_data_out),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .error_out     (error_out)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;
    bit gaps   = 1'b0;

    // Each entry: {is_pos, addr[15:0], data[95:0]}
    logic [112:0] exp_q[$];
    logic [112:0] mon_exp;
    logic [112:0] mon_act;

    function automatic void checkOutput(input string name, input logic [191:0] act,
                                        input logic [191:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    // Monitor: every write pulse must match the oldest queued expectation.
    always @(negedge clk_in) begin
        if (rst_n_in && (pos_we_out || idx_we_out)) begin
            checkOutput("we_exclusive", 192'(pos_we_out & idx_we_out), 192'd0);
            if (pos_we_out)
                mon_act = {1'b1, 4'h0, pos_addr_out, pos_data_out};
            else
                mon_act = {1'b0, idx_addr_out, 60'h0, idx_data_out};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got %h expected none", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("write", 192'(mon_act), 192'(mon_exp));
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        if (gaps) begin
            while ($urandom_range(1, 0) == 1) begin
                @(negedge clk_in);
                byte_valid_in = 1'b0;
            end
        end
        @(negedge clk_in);
        byte_valid_in = 1'b1;
        byte_in       = b;
    endtask

    task automatic idleCycle();
        @(negedge clk_in);
        byte_valid_in = 1'b0;
    endtask

    task automatic send16(input logic [15:0] v);
        applyStimulus(v[7:0]);
        applyStimulus(v[15:8]);
    endtask

    task automatic send32(input logic [31:0] v);
        send16(v[15:0]);
        send16(v[31:16]);
    endtask

    task automatic sendHeader(input logic [15:0] p, input logic [15:0] n);
        send16(p);
        send16(n);
    endtask

    task automatic sendPos(input int addr, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] z);
        send32(x);
        send32(y);
        send32(z);
        exp_q.push_back({1'b1, 16'(addr), z, y, x});
    endtask

    task automatic sendIdx(input int addr, input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2);
        send16(w0);
        send16(w1);
        send16(w2);
        exp_q.push_back({1'b0, 16'(addr), 60'h0, w0[11:0], w1[11:0], w2[11:0]});
    endtask

    task automatic pushTerm(input logic [15:0] n);
        exp_q.push_back({1'b0, n, 60'h0, 12'hFFF, 24'h0});
    endtask

    task automatic startLoad();
        @(negedge clk_in);
        start_in      = 1'b1;
        byte_valid_in = 1'b0;
        @(negedge clk_in);
        start_in = 1'b0;
    endtask

    task automatic waitDone(input logic exp_err);
        int n = 0;
        while (!done_out && n < 300) begin
            @(negedge clk_in);
            n++;
        end
        checkOutput("done", 192'(done_out), 192'd1);
        @(negedge clk_in);
        checkOutput("pending_writes", 192'(exp_q.size()), 192'd0);
        checkOutput("busy_after_done", 192'(busy_out), 192'd0);
        checkOutput("done_held", 192'(done_out), 192'd1);
        checkOutput("error_flag", 192'(error_out), 192'(exp_err));
    endtask

    task automatic stream1();
        sendHeader(16'd2, 16'd3);
        sendPos(0, 32'h3F80_0000, 32'h4000_0000, 32'hC040_0000);
        sendPos(1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0BAD_F00D);
        sendIdx(0, 16'h0001, 16'h0010, 16'h0100);
        sendIdx(1, 16'hA000, 16'h1FFF, 16'h0ABC);
        sendIdx(2, 16'h0001, 16'h0002, 16'h0003);
        pushTerm(16'd3);
        idleCycle();
    endtask

    function automatic logic [191:0] allOutputs();
        return 192'({pos_we_out, pos_addr_out, pos_data_out, idx_we_out, idx_addr_out,
                     idx_data_out, busy_out, done_out, error_out});
    endfunction

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n_in      = 1'b0;
        start_in      = 1'b0;
        byte_valid_in = 1'b0;
        byte_in       = 8'h00;
        #12;
        checkOutput("reset_outputs", allOutputs(), 192'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        $display("[TB] basic P=2 N=3");
        startLoad();
        checkOutput("busy_in_header", 192'(busy_out), 192'd1);
        stream1();
        waitDone(1'b0);

        $display("[TB] same stream with random valid gaps");
        gaps = 1'b1;
        startLoad();
        stream1();
        waitDone(1'b0);
        gaps = 1'b0;

        $display("[TB] P=5000 clamps to 4095");
        startLoad();
        sendHeader(16'd5000, 16'd0);
        idleCycle();
        checkOutput("clamp_error_early", 192'(error_out), 192'd1);
        for (int i = 0; i < 4095; i++) begin
            sendPos(i, 32'(i), ~32'(i), 32'(i) * 32'd3);
        end
        pushTerm(16'd0);
        idleCycle();
        waitDone(1'b1);

        $display("[TB] out-of-range position id");
        startLoad();
        sendHeader(16'd2, 16'd1);
        sendPos(0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003);
        sendPos(1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF);
        sendIdx(0, 16'hF002, 16'h0005, 16'h0006);
        pushTerm(16'd1);
        idleCycle();
        waitDone(1'b1);

        $display("[TB] empty model P=0 N=0");
        startLoad();
        sendHeader(16'd0, 16'd0);
        pushTerm(16'd0);
        idleCycle();
        checkOutput("empty_done_1cyc", 192'(done_out), 192'd0);
        checkOutput("empty_busy_1cyc", 192'(busy_out), 192'd1);
        @(negedge clk_in);
        checkOutput("empty_done_2cyc", 192'(done_out), 192'd1);
        checkOutput("empty_term_we", 192'(idx_we_out), 192'd1);
        waitDone(1'b0);

        $display("[TB] reset during position record 1");
        startLoad();
        sendHeader(16'd2, 16'd3);
        sendPos(0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0123_4567);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'(8'h40 + i));
        end
        @(negedge clk_in);
        byte_valid_in = 1'b0;
        #2;
        rst_n_in = 1'b0;
        #1;
        checkOutput("async_reset_outputs", allOutputs(), 192'd0);
        checkOutput("queue_after_reset", 192'(exp_q.size()), 192'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        checkOutput("idle_after_reset", allOutputs(), 192'd0);
        startLoad();
        stream1();
        waitDone(1'b0);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
